// File: rtl/io_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : io_bus_master
//  Purpose  : CPU-side initiator for the expansion-card I/O bus. Accepts one
//             read/write request at a time, sequences select/address/strobes
//             and the shared data bus, and returns one response per request.
//  Options  : IO_MASTER_WAIT_EN - adds i_ioWait strobe extension (MAX_WAIT)
//  Revision : 1.0 - initial release
// ============================================================================
module io_bus_master #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int MAX_WAIT      = 8
) (
`ifdef IO_MASTER_WAIT_EN
  input  logic       i_ioWait,
`endif
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_reqValid,
  output logic       o_reqReady,
  input  logic       i_reqWrite,
  input  logic [7:0] i_reqAddr,
  input  logic [7:0] i_reqData,
  output logic       o_rspValid,
  output logic [7:0] o_rspData,
  output logic       o_rspTimeout,
  output logic       o_ioSelect,
  output logic [7:0] o_ioAddress,
  output logic       o_ioNOE,
  output logic       o_ioNWE,
  output logic [7:0] o_bus,
  output logic       o_busDrive,
  input  logic [7:0] i_bus,
  input  logic       i_busNOE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // Counter reload values: the counter counts down to zero inside a state.
  localparam logic [3:0] C_SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] C_STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       write_q;
  logic [7:0] cap_q;        // captured read data (or 0x00 for writes)
  logic       flag_q;       // captured timeout flag
  logic       waitExtend_d; // extend the strobe by one more cycle
  logic       waitOverrun_d;// card still waiting after the extension budget

`ifdef IO_MASTER_WAIT_EN
  logic [7:0] waitCnt_q;

  assign waitExtend_d  = i_ioWait && (waitCnt_q < 8'(MAX_WAIT));
  assign waitOverrun_d = i_ioWait && !waitExtend_d;

  // Count granted strobe extensions; cleared outside the strobe phase.
  always_ff @(posedge i_clk) begin
    if (i_reset || (state_q != S_STROBE)) begin
      waitCnt_q <= 8'd0;
    end else if ((cnt_q == 4'd0) && waitExtend_d && (waitCnt_q != 8'hFF)) begin
      waitCnt_q <= waitCnt_q + 8'd1;
    end
  end
`else
  assign waitExtend_d  = 1'b0;
  assign waitOverrun_d = 1'b0;
`endif

  // Ready is a pure decode of the registered state.
  assign o_reqReady = (state_q == S_IDLE);

  // Transaction sequencer; every bus/response output is registered here.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      cap_q        <= 8'h00;
      flag_q       <= 1'b0;
      o_ioSelect   <= 1'b0;
      o_ioAddress  <= 8'h00;
      o_ioNOE      <= 1'b1;
      o_ioNWE      <= 1'b1;
      o_bus        <= 8'h00;
      o_busDrive   <= 1'b0;
      o_rspValid   <= 1'b0;
      o_rspData    <= 8'h00;
      o_rspTimeout <= 1'b0;
    end else begin
      o_rspValid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_reqValid) begin
            state_q     <= S_SETUP;
            cnt_q       <= C_SETUP_LOAD;
            write_q     <= i_reqWrite;
            o_ioSelect  <= 1'b1;
            o_ioAddress <= i_reqAddr;
            o_busDrive  <= i_reqWrite;
            o_bus       <= i_reqWrite ? i_reqData : 8'h00;
          end
        end
        S_SETUP: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_STROBE;
            cnt_q   <= C_STROBE_LOAD;
            o_ioNWE <= !write_q;
            o_ioNOE <= write_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_STROBE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (!waitExtend_d) begin
            // True last strobe cycle: release strobes and capture the result.
            state_q <= S_HOLD;
            o_ioNOE <= 1'b1;
            o_ioNWE <= 1'b1;
            if (waitOverrun_d) begin
              cap_q  <= write_q ? 8'h00 : 8'hFF;
              flag_q <= 1'b1;
            end else if (write_q) begin
              cap_q  <= 8'h00;
              flag_q <= 1'b0;
            end else if (!i_busNOE) begin
              cap_q  <= i_bus;
              flag_q <= 1'b0;
            end else begin
              cap_q  <= 8'hFF;
              flag_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          state_q      <= S_RESP;
          o_ioSelect   <= 1'b0;
          o_ioAddress  <= 8'h00;
          o_busDrive   <= 1'b0;
          o_bus        <= 8'h00;
          o_rspValid   <= 1'b1;
          o_rspData    <= cap_q;
          o_rspTimeout <= flag_q;
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          o_rspData    <= 8'h00;
          o_rspTimeout <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_bus_master
//  Purpose  : Self-checking bench for io_bus_master: directed cases plus
//             randomized transactions against a cycle-timeline reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_bus_master;

  localparam int SETUP_CYCLES  = 1;
  localparam int STROBE_CYCLES = 2;
  localparam int MAX_WAIT      = 8;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_reqValid = 1'b0;
  logic       i_reqWrite = 1'b0;
  logic [7:0] i_reqAddr = 8'h00;
  logic [7:0] i_reqData = 8'h00;
  logic       o_reqReady, o_rspValid, o_rspTimeout;
  logic [7:0] o_rspData, o_ioAddress, o_bus;
  logic       o_ioSelect, o_ioNOE, o_ioNWE, o_busDrive;
  logic [7:0] i_bus;
  logic       i_busNOE;
  logic       i_ioWait;

  // Card model controls
  logic       cardPresent = 1'b0;
  logic [7:0] cardData = 8'h00;
  int         waitLen = 0;
  int         strobeCnt = 0;
  logic       strobeLow;

  int nTests = 0;
  int nFail  = 0;

  io_bus_master #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .STROBE_CYCLES(STROBE_CYCLES),
    .MAX_WAIT     (MAX_WAIT)
  ) dut (
`ifdef IO_MASTER_WAIT_EN
    .i_ioWait    (i_ioWait),
`endif
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_reqValid  (i_reqValid),
    .o_reqReady  (o_reqReady),
    .i_reqWrite  (i_reqWrite),
    .i_reqAddr   (i_reqAddr),
    .i_reqData   (i_reqData),
    .o_rspValid  (o_rspValid),
    .o_rspData   (o_rspData),
    .o_rspTimeout(o_rspTimeout),
    .o_ioSelect  (o_ioSelect),
    .o_ioAddress (o_ioAddress),
    .o_ioNOE     (o_ioNOE),
    .o_ioNWE     (o_ioNWE),
    .o_bus       (o_bus),
    .o_busDrive  (o_busDrive),
    .i_bus       (i_bus),
    .i_busNOE    (i_busNOE)
  );

  always #5 i_clk = ~i_clk;

  // Card: drives the bus while NOE is low; optionally asserts wait starting
  // at the last nominal strobe cycle for waitLen consecutive cycles.
  always_comb begin
    strobeLow = !o_ioNOE || !o_ioNWE;
    i_busNOE  = !(cardPresent && !o_ioNOE);
    i_bus     = (cardPresent && !o_ioNOE) ? cardData : 8'hC3;
    i_ioWait  = strobeLow && (strobeCnt >= STROBE_CYCLES - 1) &&
                ((strobeCnt - (STROBE_CYCLES - 1)) < waitLen);
  end

  always @(posedge i_clk) strobeCnt <= strobeLow ? strobeCnt + 1 : 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference timeline: cycle k after the accept edge. SETUP occupies
  // 1..S, strobe S+1..S+St+W, hold the next cycle, response after that.
  task automatic run_trace(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                           input string name);
    int   S, St, W, L;
    logic ovr, act, strb, expTo;
    logic [7:0] expData;
    logic [5:0] expCtl;
    S  = SETUP_CYCLES;
    St = STROBE_CYCLES;
`ifdef IO_MASTER_WAIT_EN
    W   = (waitLen > MAX_WAIT) ? MAX_WAIT : waitLen;
    ovr = (waitLen > MAX_WAIT);
`else
    W   = 0;
    ovr = 1'b0;
`endif
    L       = S + St + W + 2;
    expTo   = ovr || (!wr && !cardPresent);
    expData = wr ? 8'h00 : (expTo ? 8'hFF : cardData);
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge i_clk);
      act    = (k <= S + St + W + 1);
      strb   = (k >= S + 1) && (k <= S + St + W);
      expCtl = {k == L + 1, act, !(strb && !wr), !(strb && wr), act && wr, k == L};
      check_val($sformatf("%s ctl T%0d", name, k),
                32'({o_reqReady, o_ioSelect, o_ioNOE, o_ioNWE, o_busDrive, o_rspValid}),
                32'(expCtl));
      if (act) check_val($sformatf("%s addr T%0d", name, k), 32'(o_ioAddress), 32'(addr));
      if (act && wr) check_val($sformatf("%s bus T%0d", name, k), 32'(o_bus), 32'(data));
      if (k == L) begin
        check_val($sformatf("%s rspData", name), 32'(o_rspData), 32'(expData));
        check_val($sformatf("%s rspTimeout", name), 32'(o_rspTimeout), 32'(expTo));
      end
    end
  endtask

  // Present a request at a negedge, let it be accepted, then follow it.
  task automatic do_txn(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                        input string name);
    i_reqValid = 1'b1;
    i_reqWrite = wr;
    i_reqAddr  = addr;
    i_reqData  = data;
    check_val($sformatf("%s ready", name), 32'(o_reqReady), 32'd1);
    @(posedge i_clk);
    #1 i_reqValid = 1'b0;
    run_trace(wr, addr, data, name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;

    // Idle after reset
    for (int k = 0; k < 5; k++) begin
      check_val($sformatf("idle ctl %0d", k),
                32'({o_reqReady, o_ioSelect, o_ioNOE, o_ioNWE, o_busDrive, o_rspValid}),
                32'(6'b101100));
      check_val($sformatf("idle rsp %0d", k),
                32'({o_rspData, o_rspTimeout, o_ioAddress, o_bus}), 32'd0);
      @(negedge i_clk);
    end

    // Directed cases
    cardPresent = 1'b0;
    do_txn(1'b1, 8'h03, 8'h41, "wr03");
    cardPresent = 1'b1; cardData = 8'h01;
    do_txn(1'b0, 8'h01, 8'h00, "rd01");
    cardPresent = 1'b0;
    do_txn(1'b0, 8'h7E, 8'h00, "rd7E_nocard");

    // Reset in the middle of a read; the request stays valid throughout
    cardPresent = 1'b1; cardData = 8'hA5;
    i_reqValid = 1'b1; i_reqWrite = 1'b0; i_reqAddr = 8'h22; i_reqData = 8'h00;
    @(posedge i_clk);            // accept edge
    @(posedge i_clk);            // end of setup
    #1 i_reset = 1'b1;
    @(negedge i_clk);
    check_val("rst strobe NOE", 32'(o_ioNOE), 32'd0);
    @(negedge i_clk);
    check_val("rst idle ctl",
              32'({o_reqReady, o_ioSelect, o_ioNOE, o_ioNWE, o_busDrive, o_rspValid}),
              32'(6'b101100));
    check_val("rst idle addr", 32'(o_ioAddress), 32'd0);
    i_reset = 1'b0;
    @(posedge i_clk);            // held request accepted
    #1 i_reqValid = 1'b0;
    run_trace(1'b0, 8'h22, 8'h00, "rd_after_rst");

    // Randomized transactions
    for (int n = 0; n < 16; n++) begin
      logic       wr;
      logic [7:0] a, d;
      wr          = 1'($urandom_range(0, 1));
      a           = 8'($urandom);
      d           = 8'($urandom);
      cardPresent = 1'($urandom_range(0, 1));
      cardData    = 8'($urandom);
`ifdef IO_MASTER_WAIT_EN
      waitLen     = $urandom_range(0, 11);
`endif
      do_txn(wr, a, d, $sformatf("rnd%0d", n));
    end

`ifdef IO_MASTER_WAIT_EN
    cardPresent = 1'b1; cardData = 8'h5A; waitLen = 3;
    do_txn(1'b0, 8'h10, 8'h00, "wait3");
    waitLen = 20;
    do_txn(1'b0, 8'h11, 8'h00, "wait20");
    do_txn(1'b1, 8'h12, 8'h77, "wait20wr");
    waitLen = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
